// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared control-flow definitions for the branch resolve unit.
//   - RISC-V opcode constants for B-type, JAL and JALR
//   - B-type funct3 condition codes
//   - 2-bit saturating counter type, its reset default and update function
//   - raw immediate extraction helpers (caller sign-extends to its XLEN)
package rv_ctrl_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  typedef logic [1:0] bht_ctr_t;

  // Weakly not-taken.
  localparam bht_ctr_t BHT_INIT_DEFAULT = 2'b01;

  // Saturating 2-bit counter step toward the observed direction.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t res;
    res = ctr;
    if (taken && (ctr != 2'b11)) res = ctr + 2'd1;
    else if (!taken && (ctr != 2'b00)) res = ctr - 2'd1;
    return res;
  endfunction

  // Immediates are returned at their natural width; bit 0 of B/J is the
  // implicit zero, the MSB is the sign bit.
  function automatic logic [12:0] imm_b(input logic [31:0] ir);
    return {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [20:0] imm_j(input logic [31:0] ir);
    return {ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

  function automatic logic [11:0] imm_i(input logic [31:0] ir);
    return ir[31:20];
  endfunction

endpackage

// File: rtl/bht_counters.sv
// bht_counters: array of 2-bit saturating counters.
//   clk_i, rst_ni   : clock, asynchronous active-low reset (all entries -> INIT)
//   rd_idx_i/rd_ctr_o : combinational read port
//   we_i, wr_idx_i, wr_taken_i : write port; the addressed counter steps
//                     toward wr_taken_i at the clock edge
// A read of the entry being written returns the old value in that cycle.
module bht_counters
  import rv_ctrl_pkg::*;
#(
  parameter int       DEPTH = 64,
  parameter bht_ctr_t INIT  = BHT_INIT_DEFAULT,
  localparam int      IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  bht_ctr_t ctr_q [DEPTH];
  bht_ctr_t ctr_d;

  // Read-modify-write happens inside the array so the caller needs no
  // second read port for training.
  assign ctr_d    = ctr_next(ctr_q[wr_idx_i], wr_taken_i);
  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= INIT;
    end else if (we_i) begin
      ctr_q[wr_idx_i] <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves B-type, JAL and JALR at the end of execute,
// trains a bimodal BHT and presents a one-stage registered result.
//   iCLK, iRST_N       : clock, asynchronous active-low reset
//   iFLUSH             : kills the pending result and the current accept
//   iVALID / oREADY    : input handshake
//   iPC, iIR, iREG_OUT1, iREG_OUT2, iPRED_TAKEN : instruction operands
//   iFETCH_PC / oPRED_TAKEN : fetch-side BHT lookup (combinational)
//   oVALID / iREADY    : output handshake
//   oTAKEN, oTARGET, oLINK, oREDIRECT, oREDIRECT_PC, oILLEGAL, oMISALIGNED
//                      : registered resolution result
module branch_resolve_unit
  import rv_ctrl_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] BHT_INIT  = BHT_INIT_DEFAULT
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            iFLUSH,
  input  logic            iVALID,
  output logic            oREADY,
  input  logic [XLEN-1:0] iPC,
  input  logic [31:0]     iIR,
  input  logic [XLEN-1:0] iREG_OUT1,
  input  logic [XLEN-1:0] iREG_OUT2,
  input  logic            iPRED_TAKEN,
  input  logic [XLEN-1:0] iFETCH_PC,
  output logic            oPRED_TAKEN,
  output logic            oVALID,
  input  logic            iREADY,
  output logic            oTAKEN,
  output logic [XLEN-1:0] oTARGET,
  output logic [XLEN-1:0] oLINK,
  output logic            oREDIRECT,
  output logic [XLEN-1:0] oREDIRECT_PC,
  output logic            oILLEGAL,
  output logic            oMISALIGNED
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high. oREADY = !oVALID || iREADY, so a slot frees in the same cycle the
  // consumer takes the result. While oVALID && !iREADY everything is held.
  // iFLUSH overrides both: the result register empties and nothing is taken.
  logic accept;

  // Decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_b, is_jal, is_jalr, b_legal, cond;

  logic [XLEN-1:0] imm_b_x, imm_j_x, imm_i_x, pc_plus4;

  logic            valid_q;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] link_q, link_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            illegal_q, illegal_d;
  logic            misaligned_q, misaligned_d;

  logic [1:0] fetch_ctr;
  logic       bht_we;

  assign opcode  = iIR[6:0];
  assign funct3  = iIR[14:12];
  assign is_b    = (opcode == OP_BRANCH);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);
  assign b_legal = is_b && (funct3 != 3'd2) && (funct3 != 3'd3);

  assign imm_b_x  = {{(XLEN-13){iIR[31]}}, imm_b(iIR)};
  assign imm_j_x  = {{(XLEN-21){iIR[31]}}, imm_j(iIR)};
  assign imm_i_x  = {{(XLEN-12){iIR[31]}}, imm_i(iIR)};
  assign pc_plus4 = iPC + XLEN'(4);

  always_comb begin
    cond = 1'b0;
    unique case (funct3)
      F3_BEQ:  cond = (iREG_OUT1 == iREG_OUT2);
      F3_BNE:  cond = (iREG_OUT1 != iREG_OUT2);
      F3_BLT:  cond = ($signed(iREG_OUT1) <  $signed(iREG_OUT2));
      F3_BGE:  cond = ($signed(iREG_OUT1) >= $signed(iREG_OUT2));
      F3_BLTU: cond = (iREG_OUT1 <  iREG_OUT2);
      F3_BGEU: cond = (iREG_OUT1 >= iREG_OUT2);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    taken_d       = 1'b0;
    target_d      = '0;
    link_d        = '0;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    illegal_d     = 1'b0;
    if (is_b) begin
      taken_d       = b_legal && cond;
      target_d      = iPC + imm_b_x;
      redirect_d    = (taken_d != iPRED_TAKEN);
      redirect_pc_d = taken_d ? target_d : pc_plus4;
      illegal_d     = !b_legal;
    end else if (is_jal) begin
      taken_d       = 1'b1;
      target_d      = iPC + imm_j_x;
      link_d        = pc_plus4;
      redirect_d    = !iPRED_TAKEN;
      redirect_pc_d = target_d;
    end else if (is_jalr) begin
      // No target predictor exists, so JALR always redirects.
      taken_d       = 1'b1;
      target_d      = (iREG_OUT1 + imm_i_x) & ~XLEN'(1);
      link_d        = pc_plus4;
      redirect_d    = 1'b1;
      redirect_pc_d = target_d;
    end else begin
      illegal_d     = 1'b1;
    end
    misaligned_d = taken_d && target_d[1];
  end

  assign oREADY = !valid_q || iREADY;
  assign accept = iVALID && oREADY && !iFLUSH;
  assign bht_we = accept && b_legal;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      valid_q       <= 1'b0;
      taken_q       <= 1'b0;
      target_q      <= '0;
      link_q        <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
      misaligned_q  <= 1'b0;
    end else if (iFLUSH) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q       <= 1'b1;
      taken_q       <= taken_d;
      target_q      <= target_d;
      link_q        <= link_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
      misaligned_q  <= misaligned_d;
    end else if (iREADY) begin
      valid_q <= 1'b0;
    end
  end

  bht_counters #(
    .DEPTH (BHT_DEPTH),
    .INIT  (BHT_INIT)
  ) u_bht (
    .clk_i      (iCLK),
    .rst_ni     (iRST_N),
    .rd_idx_i   (iFETCH_PC[IDX_W+1:2]),
    .rd_ctr_o   (fetch_ctr),
    .we_i       (bht_we),
    .wr_idx_i   (iPC[IDX_W+1:2]),
    .wr_taken_i (taken_d)
  );

  // Fetch PC bits outside the index field do not participate in the lookup.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{iFETCH_PC[1:0], iFETCH_PC[XLEN-1:IDX_W+2]};

  assign oPRED_TAKEN  = fetch_ctr[1];
  assign oVALID       = valid_q;
  assign oTAKEN       = taken_q;
  assign oTARGET      = target_q;
  assign oLINK        = link_q;
  assign oREDIRECT    = redirect_q;
  assign oREDIRECT_PC = redirect_pc_q;
  assign oILLEGAL     = illegal_q;
  assign oMISALIGNED  = misaligned_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, pipelined successor to the combinational B-type branch evaluator; sits at the end of the execute stage.
- Resolves all control-flow instructions: the six B-type conditions, JAL and JALR, with correct signed/unsigned compares.
- Holds a bimodal branch history table (BHT) of 2-bit saturating counters; fetch reads it and resolution trains it.
- Presents a one-stage registered result with a valid/ready handshake and a mispredict redirect.

Parameters:
XLEN, 32, datapath and PC width (32 or 64)
BHT_DEPTH, 64, number of 2-bit counters; power of 2, at least 2
BHT_INIT, 2'b01, counter value at reset (weakly not-taken)

Ports:
iCLK  in  1  clock, rising edge
iRST_N  in  1  asynchronous active-low reset
iFLUSH  in  1  synchronous kill of the pending result and of the current accept
iVALID  in  1  instruction present on the input fields
oREADY  out  1  unit can accept; equals !oVALID || iREADY
iPC  in  XLEN  PC of the instruction
iIR  in  32  instruction word
iREG_OUT1  in  XLEN  rs1 value
iREG_OUT2  in  XLEN  rs2 value
iPRED_TAKEN  in  1  prediction fetch used for this instruction
iFETCH_PC  in  XLEN  fetch-side BHT lookup address
oPRED_TAKEN  out  1  combinational BHT prediction for iFETCH_PC (counter bit 1)
oVALID  out  1  result register valid
iREADY  in  1  consumer accepts the result
oTAKEN  out  1  resolved direction
oTARGET  out  XLEN  resolved taken target
oLINK  out  XLEN  iPC+4 for JAL/JALR, 0 otherwise
oREDIRECT  out  1  mispredict; fetch must restart at oREDIRECT_PC
oREDIRECT_PC  out  XLEN  correct next PC
oILLEGAL  out  1  non-control opcode, or B-type funct3 of 2 or 3
oMISALIGNED  out  1  taken target with bit 1 set

Behaviour:
- Reset (asynchronous, iRST_N=0): all outputs 0, including oVALID. oREADY=1 once released. Every BHT entry = BHT_INIT. A result in flight is lost.
- Accept occurs when iVALID && oREADY && !iFLUSH. Results are registered on that edge and visible on the following cycle (latency 1). Full throughput when iREADY stays 1.
- Hold: while oVALID && !iREADY, all outputs are stable and no new accept is taken.
- iFLUSH: at the next edge, oVALID=0 and no BHT update occurs. Flush has priority over accept and hold.
- Decode uses iIR[6:0]:
  - 1100011 = B
  - 1101111 = JAL
  - 1100111 = JALR
- Immediates, sign-extended to XLEN:
  - B: {IR[31],IR[7],IR[30:25],IR[11:8],0}
  - J: {IR[31],IR[19:12],IR[20],IR[30:21],0}
  - I: IR[31:20]
- Targets:
  - B and JAL: iPC+imm
  - JALR: (rs1+imm) with bit 0 cleared
  - All additions wrap modulo 2^XLEN
- B conditions by funct3:
  - 0 BEQ: ==
  - 1 BNE: !=
  - 4 BLT: signed <
  - 5 BGE: signed >=
  - 6 BLTU: unsigned <
  - 7 BGEU: unsigned >=
  - 2 and 3: oILLEGAL=1, oTAKEN=0, no BHT update
- Redirect rules:
  - B: oREDIRECT = (oTAKEN != iPRED_TAKEN); oREDIRECT_PC = taken ? target : iPC+4.
  - JAL: oTAKEN=1; oREDIRECT = !iPRED_TAKEN.
  - JALR: oTAKEN=1; oREDIRECT=1 always, since no target prediction exists.
  - Other opcodes: oILLEGAL=1; oTAKEN, oREDIRECT and oLINK are 0.
- oMISALIGNED = oTAKEN && target[1]. oTAKEN and oREDIRECT are still reported.
- BHT:
  - Index = PC[log2(BHT_DEPTH)+1:2].
  - Updated at the accept edge, legal B-type only: increment saturating at 3 if taken, decrement saturating at 0 if not.
  - A read of the same index in the update cycle returns the pre-update value; the new value is visible the next cycle.
  - JAL and JALR do not train the BHT.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants OP_BRANCH, OP_JAL, OP_JALR
  - funct3 constants F3_BEQ..F3_BGEU
  - the 2-bit counter type
  - BHT_INIT default
- Immediate extraction functions go in the same package.
- Sub-module bht_counters: the array with one combinational read port, one write port and asynchronous init.

Test Plan:
- Signed vs unsigned: BLT and BLTU with rs1=32'hFFFFFFFF, rs2=1, iPC=0x100, imm=+8 → BLT oTAKEN=1, oTARGET=0x108; BLTU oTAKEN=0, oREDIRECT_PC=0x104.
- BHT training: three taken BEQ at iPC=0x40 from reset, with iPRED_TAKEN matching oPRED_TAKEN → counter goes 01→10→11→11. oPRED_TAKEN for iFETCH_PC=0x40 reads 0, then 1, then 1. First branch redirects; later ones do not.
- JALR: rs1=0x1003, imm=+4 → oTARGET=0x1006, oMISALIGNED=1, oREDIRECT=1, oLINK=iPC+4.
- Backpressure: iREADY=0 for 3 cycles with iVALID held → oREADY=0, outputs stable, one BHT update only. Release → back-to-back results at one per cycle.
- Flush: iFLUSH with oVALID=1 and iVALID=1 → next cycle oVALID=0, BHT unchanged.
- Reset: assert iRST_N=0 mid-stall → oVALID drops immediately; after release every BHT read returns BHT_INIT[1]=0. Also drive funct3=2 → oILLEGAL=1.
